id_regfile_stage: RTL

Parametrised, clocked instruction-decode stage: decodes a MIPS-format instruction word, reads two operands from an internal register file, and presents the results in a valid/ready output register that feeds EX. It replaces the combinational, level-written decode block. It adds:
- a synchronous write port with write-to-read bypass;
- a hard-wired zero register;
- zero-extension for logical immediates;
- stall and flush handling.

---
 rtl/id_pkg.sv | 51 +++++
 rtl/id_regfile_stage_if.sv | 37 +++
 rtl/regfile_2r1w.sv | 69 ++++++
 rtl/id_regfile_stage.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Instruction field layout, logical-immediate opcodes and the decoded
// instruction record shared by the decode stage and its interface users.
package id_pkg;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int SHAMT_HI  = 10;
    localparam int SHAMT_LO  = 6;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;
    localparam int OFFSET_HI = 15;
    localparam int OFFSET_LO = 0;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
    } decoded_t;

    function automatic decoded_t decode(input logic [31:0] ir);
        decoded_t d;
        d.opcode = ir[OPCODE_HI:OPCODE_LO];
        d.rs     = ir[RS_HI:RS_LO];
        d.rt     = ir[RT_HI:RT_LO];
        d.rd     = ir[RD_HI:RD_LO];
        d.shamt  = ir[SHAMT_HI:SHAMT_LO];
        d.funct  = ir[FUNCT_HI:FUNCT_LO];
        d.imm    = ir[OFFSET_HI:OFFSET_LO];
        return d;
    endfunction

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic is_logical_imm(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/id_regfile_stage_if.sv
// Bundle of the decode stage's fetch, write-back and EX-side signals.
// master drives the stage inputs; slave is the stage itself.
interface id_regfile_stage_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      ir;
    logic             wb_en;
    logic [AW-1:0]    wb_reg;
    logic [WIDTH-1:0] wb_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] read_data1;
    logic [WIDTH-1:0] read_data2;
    logic [WIDTH-1:0] offset;
    logic [AW-1:0]    rs;
    logic [AW-1:0]    rt;
    logic [AW-1:0]    rd;
    logic [5:0]       opcode;
    logic [4:0]       shamt;
    logic [5:0]       funct;

    modport master (
        output in_valid, ir, wb_en, wb_reg, wb_data, flush, out_ready,
        input  in_ready, out_valid, read_data1, read_data2, offset,
               rs, rt, rd, opcode, shamt, funct
    );

    modport slave (
        input  in_valid, ir, wb_en, wb_reg, wb_data, flush, out_ready,
        output in_ready, out_valid, read_data1, read_data2, offset,
               rs, rt, rd, opcode, shamt, funct
    );
endinterface

// File: rtl/regfile_2r1w.sv
// Register file with two asynchronous read ports, one synchronous write
// port, optional hard-wired zero register and optional write-to-read bypass.
module regfile_2r1w #(
    parameter int  WIDTH    = 32,
    parameter int  NREGS    = 32,
    parameter int  ZERO_REG = 1,
    parameter int  BYPASS   = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    wa_i,
    input  logic [WIDTH-1:0] wd_i,
    input  logic [AW-1:0]    ra1_i,
    input  logic [AW-1:0]    ra2_i,
    output logic [WIDTH-1:0] rd1_o,
    output logic [WIDTH-1:0] rd2_o
);

    logic [WIDTH-1:0] mem_q [NREGS];
    logic             write_ok_s;

    function automatic logic [WIDTH-1:0] resolve(
        input logic [AW-1:0]    addr,
        input logic [WIDTH-1:0] stored,
        input logic             we,
        input logic [AW-1:0]    wa,
        input logic [WIDTH-1:0] wd
    );
        logic [WIDTH-1:0] r;
        if ((ZERO_REG != 0) && (addr == '0)) begin
            r = '0;
        end else if ((BYPASS != 0) && we && (wa == addr)) begin
            r = wd;
        end else begin
            r = stored;
        end
        return r;
    endfunction

    // Qualify the write so register 0 stays zero when it is hard-wired.
    always_comb begin
        write_ok_s = we_i;
        if ((ZERO_REG != 0) && (wa_i == '0)) begin
            write_ok_s = 1'b0;
        end else begin
            write_ok_s = we_i;
        end
    end

    // Storage array: cleared on reset, written on the edge otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_ok_s) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    // Read ports with zero-register and bypass resolution.
    always_comb begin
        rd1_o = resolve(ra1_i, mem_q[ra1_i], we_i, wa_i, wd_i);
        rd2_o = resolve(ra2_i, mem_q[ra2_i], we_i, wa_i, wd_i);
    end

endmodule

// File: rtl/id_regfile_stage.sv
// Clocked decode stage: decodes the instruction, reads operands, and holds
// the result in a valid/ready output register feeding EX.
module id_regfile_stage
    import id_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic               clk,
    input  logic               rst,
    id_regfile_stage_if.slave  bus
);

    localparam int AW = $clog2(NREGS);

    decoded_t         dec_s;
    logic             fire_s;
    logic             hold_s;
    logic             wb_eff_s;
    logic [WIDTH-1:0] rf_rd1_s;
    logic [WIDTH-1:0] rf_rd2_s;
    logic [WIDTH-1:0] offset_ext_s;

    logic             valid_q,  valid_d;
    logic [WIDTH-1:0] rd1_q,    rd1_d;
    logic [WIDTH-1:0] rd2_q,    rd2_d;
    logic [WIDTH-1:0] offset_q, offset_d;
    logic [AW-1:0]    rs_q,     rs_d;
    logic [AW-1:0]    rt_q,     rt_d;
    logic [AW-1:0]    rd_q,     rd_d;
    logic [5:0]       opcode_q, opcode_d;
    logic [4:0]       shamt_q,  shamt_d;
    logic [5:0]       funct_q,  funct_d;

    regfile_2r1w #(
        .WIDTH    (WIDTH),
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_rf (
        .clk   (clk),
        .rst   (rst),
        .we_i  (bus.wb_en),
        .wa_i  (bus.wb_reg),
        .wd_i  (bus.wb_data),
        .ra1_i (dec_s.rs[AW-1:0]),
        .ra2_i (dec_s.rt[AW-1:0]),
        .rd1_o (rf_rd1_s),
        .rd2_o (rf_rd2_s)
    );

    // Field split, immediate extension and handshake qualifiers.
    always_comb begin
        dec_s  = decode(bus.ir);
        fire_s = bus.in_valid && (!valid_q || bus.out_ready);
        hold_s = valid_q && !bus.out_ready;
        if (is_logical_imm(dec_s.opcode)) begin
            offset_ext_s = {{(WIDTH-16){1'b0}}, dec_s.imm};
        end else begin
            offset_ext_s = {{(WIDTH-16){dec_s.imm[15]}}, dec_s.imm};
        end
        if ((ZERO_REG != 0) && (bus.wb_reg == '0)) begin
            wb_eff_s = 1'b0;
        end else begin
            wb_eff_s = bus.wb_en;
        end
    end

    // Output register next state: capture wins over flush, and a stalled
    // instruction picks up write-backs to its source registers.
    always_comb begin
        valid_d  = valid_q;
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        offset_d = offset_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        opcode_d = opcode_q;
        shamt_d  = shamt_q;
        funct_d  = funct_q;
        if (fire_s) begin
            valid_d  = 1'b1;
            rd1_d    = rf_rd1_s;
            rd2_d    = rf_rd2_s;
            offset_d = offset_ext_s;
            rs_d     = dec_s.rs[AW-1:0];
            rt_d     = dec_s.rt[AW-1:0];
            rd_d     = dec_s.rd[AW-1:0];
            opcode_d = dec_s.opcode;
            shamt_d  = dec_s.shamt;
            funct_d  = dec_s.funct;
        end else begin
            if (bus.flush || (valid_q && bus.out_ready)) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
            if (hold_s && wb_eff_s && (bus.wb_reg == rs_q)) begin
                rd1_d = bus.wb_data;
            end else begin
                rd1_d = rd1_q;
            end
            if (hold_s && wb_eff_s && (bus.wb_reg == rt_q)) begin
                rd2_d = bus.wb_data;
            end else begin
                rd2_d = rd2_q;
            end
        end
    end

    // Output register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            offset_q <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            opcode_q <= 6'd0;
            shamt_q  <= 5'd0;
            funct_q  <= 6'd0;
        end else begin
            valid_q  <= valid_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            offset_q <= offset_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            opcode_q <= opcode_d;
            shamt_q  <= shamt_d;
            funct_q  <= funct_d;
        end
    end

    assign bus.in_ready   = !valid_q || bus.out_ready;
    assign bus.out_valid  = valid_q;
    assign bus.read_data1 = rd1_q;
    assign bus.read_data2 = rd2_q;
    assign bus.offset     = offset_q;
    assign bus.rs         = rs_q;
    assign bus.rt         = rt_q;
    assign bus.rd         = rd_q;
    assign bus.opcode     = opcode_q;
    assign bus.shamt      = shamt_q;
    assign bus.funct      = funct_q;

endmodule
